// File: rtl/rate_conv_sched.sv
// Round-robin scheduler feeding the shared 4-to-3 rate-converter input from
// NCH sample sources; accepted samples are registered with their channel tag.

module rcs_lane #(
   parameter int CW      = 2,
   parameter int LANE_ID = 0
) (
   input  logic          serve,
   input  logic          gate,
   input  logic [CW-1:0] grant,
   output logic          ready
);
   assign ready = serve & gate & (grant == CW'(LANE_ID));
endmodule

module rate_conv_sched #(
   parameter int DW  = 8,
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
) (
   input  logic              clk_div3,
   input  logic              reset,
   input  logic              enable,
   input  logic [3:0]        burst_len,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH*DW-1:0] req_data,
   output logic [NCH-1:0]    req_ready,
   output logic [DW-1:0]     conv_x,
   output logic [CW-1:0]     conv_ch,
   output logic              conv_vld,
   output logic              busy
);
   typedef enum logic {IDLE, SERVE} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            ptr_q, ptr_d;
   logic [CW-1:0]            grant_q, grant_d;
   logic [3:0]               blen_q, blen_d;
   logic [3:0]               bcnt_q, bcnt_d;
   logic [DW-1:0]            conv_x_q, conv_x_d;
   logic [CW-1:0]            conv_ch_q, conv_ch_d;
   logic                     conv_vld_q, conv_vld_d;

   logic [NCH-1:0][DW-1:0]   req_data_a;
   logic                     found;
   logic [CW-1:0]            pick;
   logic                     xfer;
   logic [3:0]               bcnt_inc;

   assign req_data_a = req_data;

   // Ready is also gated by reset so a source never sees its sample taken
   // on an edge where the burst is being dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_lane
      rcs_lane #(.CW(CW), .LANE_ID(i)) u_lane (
         .serve (state_q == SERVE),
         .gate  (enable & reset),
         .grant (grant_q),
         .ready (req_ready[i])
      );
   end

   // First valid source at or above ptr; NCH is a power of two so the
   // CW-bit add wraps modulo NCH for free.
   always_comb begin
      logic [CW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = ptr_q + CW'(k);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign xfer     = req_valid[grant_q] & req_ready[grant_q];
   assign bcnt_inc = bcnt_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      blen_d     = blen_q;
      bcnt_d     = bcnt_q;
      conv_x_d   = '0;
      conv_ch_d  = conv_ch_q;
      conv_vld_d = 1'b0;
      if (state_q == IDLE) begin
         if (enable && found) begin
            grant_d = pick;
            blen_d  = (burst_len == 4'd0) ? 4'd1 : burst_len;
            bcnt_d  = 4'd0;
            state_d = SERVE;
         end
      end else begin
         if (xfer) begin
            conv_x_d   = req_data_a[grant_q];
            conv_ch_d  = grant_q;
            conv_vld_d = 1'b1;
            bcnt_d     = bcnt_inc;
            if (bcnt_inc == blen_q) begin
               state_d = IDLE;
               ptr_d   = grant_q + CW'(1);
            end
         end else begin
            // A stalled or disabled source forfeits the rest of its burst.
            state_d = IDLE;
            ptr_d   = grant_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_div3) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         blen_q     <= 4'd1;
         bcnt_q     <= 4'd0;
         conv_x_q   <= '0;
         conv_ch_q  <= '0;
         conv_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         blen_q     <= blen_d;
         bcnt_q     <= bcnt_d;
         conv_x_q   <= conv_x_d;
         conv_ch_q  <= conv_ch_d;
         conv_vld_q <= conv_vld_d;
      end
   end

   assign conv_x   = conv_x_q;
   assign conv_ch  = conv_ch_q;
   assign conv_vld = conv_vld_q;
   assign busy     = (state_q == SERVE);
endmodule

// File: tb/tb_rate_conv_sched.sv
// Directed bench for rate_conv_sched: queue-backed sources, hand-derived
// expected outputs checked one cycle at a time.

module tb_rate_conv_sched;
   logic        clk_div3;
   logic        reset;
   logic        enable;
   logic [3:0]  burst_len;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  conv_x;
   logic [1:0]  conv_ch;
   logic        conv_vld;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] src_q [4][$];

   rate_conv_sched #(.DW(8), .NCH(4)) dut (
      .clk_div3  (clk_div3),
      .reset     (reset),
      .enable    (enable),
      .burst_len (burst_len),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .conv_x    (conv_x),
      .conv_ch   (conv_ch),
      .conv_vld  (conv_vld),
      .busy      (busy)
   );

   initial clk_div3 = 1'b0;
   always #5 clk_div3 = ~clk_div3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (src_q[i].size() != 0);
         req_data[i*8 +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
   endtask

   // Advance one edge; sources pop whatever was accepted on that edge.
   task automatic tick();
      logic [3:0] acc;
      #1;
      acc = req_valid & req_ready;
      @(posedge clk_div3);
      #1;
      for (int i = 0; i < 4; i++)
         if (acc[i]) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic chk_sample(input string tag, input logic [7:0] x, input logic [1:0] ch);
      chk({tag, "_vld"}, {31'd0, conv_vld}, 32'd1);
      chk({tag, "_x"},   {24'd0, conv_x},   {24'd0, x});
      chk({tag, "_ch"},  {30'd0, conv_ch},  {30'd0, ch});
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_vld"}, {31'd0, conv_vld}, 32'd0);
      chk({tag, "_x"},   {24'd0, conv_x},   32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      enable    = 1'b1;
      burst_len = 4'd0;
      for (int i = 0; i < 4; i++) src_q[i].push_back(8'hE0 + 8'(i));
      drive();

      // reset held with every source valid
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready", {28'd0, req_ready}, 32'd0);
         chk("rst_vld",   {31'd0, conv_vld},  32'd0);
         chk("rst_x",     {24'd0, conv_x},    32'd0);
         chk("rst_busy",  {31'd0, busy},      32'd0);
      end
      chk("rst_ch", {30'd0, conv_ch}, 32'd0);
      for (int i = 0; i < 4; i++) src_q[i].delete();
      drive();
      reset = 1'b1;
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // single burst on ch2, burst_len 3
      burst_len = 4'd3;
      src_q[2] = '{8'h10, 8'h11, 8'h12};
      drive();
      tick();
      chk("sb_busy",  {31'd0, busy},      32'd1);
      chk("sb_ready", {28'd0, req_ready}, 32'h4);
      chk("sb_vld0",  {31'd0, conv_vld},  32'd0);
      tick(); chk_sample("sb_s0", 8'h10, 2'd2);
      chk("sb_ready1", {28'd0, req_ready}, 32'h4);
      tick(); chk_sample("sb_s1", 8'h11, 2'd2);
      tick(); chk_sample("sb_s2", 8'h12, 2'd2);
      chk("sb_done_busy",  {31'd0, busy},      32'd0);
      chk("sb_done_ready", {28'd0, req_ready}, 32'd0);
      tick(); chk_bubble("sb_bubble");
      chk("sb_ch_hold", {30'd0, conv_ch}, 32'd2);

      // round-robin, burst_len 1, restart from ptr 0
      reset = 1'b0;
      tick();
      reset = 1'b1;
      burst_len = 4'd1;
      for (int i = 0; i < 4; i++) begin
         src_q[i].push_back(8'hA0 + 8'(i));
         src_q[i].push_back(8'hA0 + 8'(i));
      end
      drive();
      tick();
      for (int k = 0; k < 8; k++) begin
         tick(); chk_sample($sformatf("rr_s%0d", k), 8'hA0 + 8'(k % 4), 2'(k % 4));
         tick(); chk_bubble($sformatf("rr_b%0d", k));
      end

      // early end: ch1 runs dry after 2 of 4, ch3 must be served next
      burst_len = 4'd4;
      src_q[1] = '{8'h31, 8'h32};
      src_q[3] = '{8'h51, 8'h52, 8'h53, 8'h54};
      drive();
      tick();
      chk("ee_ready1", {28'd0, req_ready}, 32'h2);
      tick(); chk_sample("ee_s0", 8'h31, 2'd1);
      tick(); chk_sample("ee_s1", 8'h32, 2'd1);
      tick(); chk_bubble("ee_end");
      chk("ee_end_busy", {31'd0, busy}, 32'd0);
      src_q[1].push_back(8'h33);
      drive();
      tick();
      chk("ee_ready3", {28'd0, req_ready}, 32'h8);
      for (int k = 0; k < 4; k++) begin
         tick(); chk_sample($sformatf("ee_c3_%0d", k), 8'h51 + 8'(k), 2'd3);
      end
      tick();
      chk("ee_ready1b", {28'd0, req_ready}, 32'h2);
      tick(); chk_sample("ee_s2", 8'h33, 2'd1);
      tick(); chk_bubble("ee_end2");

      // burst_len 0 behaves as 1
      burst_len = 4'd0;
      src_q[0] = '{8'h61, 8'h62};
      drive();
      tick();
      chk("bl0_ready", {28'd0, req_ready}, 32'h1);
      tick(); chk_sample("bl0_s0", 8'h61, 2'd0);
      chk("bl0_busy0", {31'd0, busy}, 32'd0);
      tick(); chk_bubble("bl0_b0");
      chk("bl0_busy1", {31'd0, busy}, 32'd1);
      tick(); chk_sample("bl0_s1", 8'h62, 2'd0);
      tick(); chk_bubble("bl0_b1");

      // enable abort mid-burst
      burst_len = 4'd4;
      src_q[2] = '{8'h71, 8'h72, 8'h73, 8'h74};
      drive();
      tick();
      tick(); chk_sample("en_s0", 8'h71, 2'd2);
      enable = 1'b0;
      #1;
      chk("en_ready_now", {28'd0, req_ready}, 32'd0);
      tick(); chk_bubble("en_abort");
      chk("en_busy", {31'd0, busy}, 32'd0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("en_hold_busy",  {31'd0, busy},      32'd0);
         chk("en_hold_ready", {28'd0, req_ready}, 32'd0);
      end
      enable = 1'b1;
      tick();
      chk("en_regrant", {28'd0, req_ready}, 32'h4);
      for (int k = 0; k < 3; k++) begin
         tick(); chk_sample($sformatf("en_r%0d", k), 8'h72 + 8'(k), 2'd2);
      end
      tick(); chk_bubble("en_end");

      // reset during the 2nd sample of a 4-sample burst
      src_q[3] = '{8'h81, 8'h82, 8'h83, 8'h84};
      src_q[0] = '{8'h91};
      drive();
      tick();
      chk("rm_ready3", {28'd0, req_ready}, 32'h8);
      tick(); chk_sample("rm_s0", 8'h81, 2'd3);
      reset = 1'b0;
      tick();
      chk_bubble("rm_rst");
      chk("rm_ch",    {30'd0, conv_ch},   32'd0);
      chk("rm_busy",  {31'd0, busy},      32'd0);
      chk("rm_ready", {28'd0, req_ready}, 32'd0);
      reset = 1'b1;
      tick();
      chk("rm_ptr0", {28'd0, req_ready}, 32'h1);
      tick(); chk_sample("rm_s1", 8'h91, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
